ucsbece154b_branch_resolve: RTL and testbench

- Execute-stage resolver that produces every update signal the fetch-stage branch predictor (BTB + gshare) consumes: BTB write, PHT write/increment, GHR reset.
- Carries fetch-time prediction metadata down a two-stage pipe (F→D→E) under hazard-unit stall/flush.
- Compares the prediction against the actual outcome in E and raises a one-cycle mispredict with the redirect PC.

---
 rtl/ucsbece154b_branch_resolve_pkg.sv | 16 +
 rtl/ucsbece154b_bp_meta_reg.sv | 35 +++
 rtl/ucsbece154b_branch_resolve.sv | 124 ++++++++++++
 tb/tb_ucsbece154b_branch_resolve.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// Shared opcode constants and prediction-metadata record sizing for the
// branch resolver and its metadata pipe registers.
package ucsbece154b_branch_resolve_pkg;

    localparam logic [6:0] instr_branch_op = 7'b1100011;
    localparam logic [6:0] instr_jal_op    = 7'b1101111;
    localparam logic [6:0] instr_jalr_op   = 7'b1100111;

    // Record layout, MSB first: {valid, pc, predTaken, predTarget, phtAddr}
    localparam int META_FIXED_W = 1 + 32 + 1 + 32;

    function automatic int meta_width(input int ghr_bits);
        return META_FIXED_W + ghr_bits;
    endfunction

endpackage

// File: rtl/ucsbece154b_bp_meta_reg.sv
// One prediction-metadata pipe register with stall/flush; flush has priority
// over stall, and a flushed record is cleared entirely.
module ucsbece154b_bp_meta_reg
    import ucsbece154b_branch_resolve_pkg::*;
#(
    parameter int W = meta_width(5)
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic [W-1:0] rec_i,
    output logic [W-1:0] rec_o
);

    logic [W-1:0] rec_q, rec_d;

    always_comb begin
        rec_d = rec_q;
        if (flush_i)
            rec_d = '0;
        else if (!stall_i)
            rec_d = rec_i;
    end

    always_ff @(posedge clk) begin
        if (reset_i)
            rec_q <= '0;
        else
            rec_q <= rec_d;
    end

    assign rec_o = rec_q;

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// Execute-stage branch resolver: carries fetch-time prediction metadata to E and
// generates BTB/PHT/GHR updates plus mispredict redirect. Optional BP_RESOLVE_STATS_EN.
module ucsbece154b_branch_resolve
    import ucsbece154b_branch_resolve_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic                               StallD_i,
    input  logic                               FlushD_i,
    input  logic                               FlushE_i,
    input  logic [31:0]                        PCF_i,
    input  logic                               BranchTakenF_i,
    input  logic [31:0]                        BTBtargetF_i,
    input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
    input  logic [6:0]                         opE_i,
    input  logic                               ActualTakenE_i,
    input  logic [31:0]                        ActualTargetE_i,
    output logic                               BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic [31:0]                        UpdatePC_o,
    output logic                               PHTwe_o,
    output logic                               PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               GHRreset_o,
`ifdef BP_RESOLVE_STATS_EN
    output logic [31:0]                        BranchCount_o,
    output logic [31:0]                        MispredictCount_o,
`endif
    output logic                               Mispredict_o,
    output logic [31:0]                        RedirectPC_o
);

    localparam int IDX = $clog2(NUM_BTB_ENTRIES);
    localparam int MW  = meta_width(NUM_GHR_BITS);

    logic [MW-1:0] recF, recD, recE;

    assign recF = {1'b1, PCF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i};

    ucsbece154b_bp_meta_reg #(.W(MW)) u_meta_d (
        .clk(clk), .reset_i(reset_i), .stall_i(StallD_i), .flush_i(FlushD_i),
        .rec_i(recF), .rec_o(recD)
    );

    // A mispredict squashes whatever follows it into E on the next edge.
    ucsbece154b_bp_meta_reg #(.W(MW)) u_meta_e (
        .clk(clk), .reset_i(reset_i), .stall_i(1'b0), .flush_i(FlushE_i | Mispredict_o),
        .rec_i(recD), .rec_o(recE)
    );

    logic                    e_valid, e_pt;
    logic [31:0]             e_pc, e_tgt;
    logic [NUM_GHR_BITS-1:0] e_pht;
    logic                    ev, is_br, is_j, taken, tgt_bad;

    assign e_valid = recE[MW-1];
    assign e_pc    = recE[MW-2 -: 32];
    assign e_pt    = recE[MW-34];
    assign e_tgt   = recE[MW-35 -: 32];
    assign e_pht   = recE[NUM_GHR_BITS-1:0];

    // Gating with reset keeps the reset cycle itself free of updates.
    assign ev      = e_valid & ~reset_i;
    assign is_br   = (opE_i == instr_branch_op);
    assign is_j    = (opE_i == instr_jal_op) | (opE_i == instr_jalr_op);
    assign taken   = is_j | (is_br & ActualTakenE_i);
    assign tgt_bad = (e_tgt != ActualTargetE_i);

    always_comb begin
        Mispredict_o      = 1'b0;
        RedirectPC_o      = '0;
        BTB_we_o          = 1'b0;
        BTBwriteaddress_o = '0;
        BTBwritedata_o    = '0;
        UpdatePC_o        = '0;
        PHTwe_o           = 1'b0;
        PHTincrement_o    = 1'b0;
        PHTwriteaddress_o = '0;
        GHRreset_o        = 1'b0;
        if (ev) begin
            Mispredict_o      = (e_pt != taken) | (taken & tgt_bad);
            RedirectPC_o      = taken ? ActualTargetE_i : e_pc + 32'd4;
            BTB_we_o          = (is_br | is_j) & taken & (~e_pt | tgt_bad);
            BTBwriteaddress_o = e_pc[IDX+1:2];
            BTBwritedata_o    = ActualTargetE_i;
            UpdatePC_o        = e_pc;
            PHTwe_o           = is_br;
            PHTincrement_o    = ActualTakenE_i;
            PHTwriteaddress_o = e_pht;
            GHRreset_o        = Mispredict_o & is_br;
        end
    end

`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (ev & (is_br | is_j) & (br_cnt_q != 32'hFFFF_FFFF))
            br_cnt_d = br_cnt_q + 32'd1;
        if (Mispredict_o & (mis_cnt_q != 32'hFFFF_FFFF))
            mis_cnt_d = mis_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign BranchCount_o     = br_cnt_q;
    assign MispredictCount_o = mis_cnt_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Self-checking bench for ucsbece154b_branch_resolve: directed scenarios plus
// randomized traffic checked against a pipeline-level reference model.
module tb_ucsbece154b_branch_resolve;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    logic        clk = 0;
    logic        reset_i = 1, StallD_i = 0, FlushD_i = 0, FlushE_i = 0;
    logic [31:0] PCF_i = 0, BTBtargetF_i = 0, ActualTargetE_i = 0;
    logic        BranchTakenF_i = 0, ActualTakenE_i = 0;
    logic [4:0]  PHTreadaddressF_i = 0;
    logic [6:0]  opE_i = OP_ADD;

    logic        BTB_we_o, PHTwe_o, PHTincrement_o, GHRreset_o, Mispredict_o;
    logic [4:0]  BTBwriteaddress_o, PHTwriteaddress_o;
    logic [31:0] BTBwritedata_o, UpdatePC_o, RedirectPC_o;
`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] BranchCount_o, MispredictCount_o;
    logic [31:0] m_bc, m_mc;
`endif

    int checks = 0;
    int errors = 0;

    ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
        .clk(clk), .reset_i(reset_i), .StallD_i(StallD_i), .FlushD_i(FlushD_i),
        .FlushE_i(FlushE_i), .PCF_i(PCF_i), .BranchTakenF_i(BranchTakenF_i),
        .BTBtargetF_i(BTBtargetF_i), .PHTreadaddressF_i(PHTreadaddressF_i),
        .opE_i(opE_i), .ActualTakenE_i(ActualTakenE_i), .ActualTargetE_i(ActualTargetE_i),
        .BTB_we_o(BTB_we_o), .BTBwriteaddress_o(BTBwriteaddress_o),
        .BTBwritedata_o(BTBwritedata_o), .UpdatePC_o(UpdatePC_o), .PHTwe_o(PHTwe_o),
        .PHTincrement_o(PHTincrement_o), .PHTwriteaddress_o(PHTwriteaddress_o),
        .GHRreset_o(GHRreset_o),
`ifdef BP_RESOLVE_STATS_EN
        .BranchCount_o(BranchCount_o), .MispredictCount_o(MispredictCount_o),
`endif
        .Mispredict_o(Mispredict_o), .RedirectPC_o(RedirectPC_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic [4:0]  pht;
    } rec_t;

    rec_t mD = '0, mE = '0;

    // Expected outputs for the current cycle
    logic        x_mis, x_btbwe, x_phtwe, x_inc, x_ghr, x_ctl;
    logic [31:0] x_red, x_data, x_upc;
    logic [4:0]  x_baddr, x_paddr;

    task automatic expect_now();
        logic br, jmp, tk, live;
        live = mE.v && !reset_i;
        br   = (opE_i == OP_BR);
        jmp  = (opE_i == OP_JAL) || (opE_i == OP_JALR);
        tk   = jmp || (br && ActualTakenE_i);
        x_ctl   = live && (br || jmp);
        x_mis   = live && ((mE.pt != tk) || (tk && mE.tgt != ActualTargetE_i));
        x_red   = !live ? 32'd0 : (tk ? ActualTargetE_i : mE.pc + 32'd4);
        x_btbwe = live && (br || jmp) && tk && (!mE.pt || mE.tgt != ActualTargetE_i);
        x_baddr = live ? 5'((mE.pc / 4) % 32) : 5'd0;
        x_data  = live ? ActualTargetE_i : 32'd0;
        x_upc   = live ? mE.pc : 32'd0;
        x_phtwe = live && br;
        x_inc   = live && ActualTakenE_i;
        x_paddr = live ? mE.pht : 5'd0;
        x_ghr   = x_mis && br;
    endtask

    // Wait to the falling edge, then compare every output against the model.
    task automatic settle();
        @(negedge clk);
        expect_now();
        checks++;
        if ({Mispredict_o, RedirectPC_o, BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
             UpdatePC_o, PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o} !==
            {x_mis, x_red, x_btbwe, x_baddr, x_data, x_upc, x_phtwe, x_inc, x_paddr, x_ghr}) begin
            errors++;
            $display("FAIL model t=%0t mis %b/%b red %h/%h btbwe %b/%b baddr %0d/%0d data %h/%h upc %h/%h phtwe %b/%b inc %b/%b paddr %0d/%0d ghr %b/%b (got/exp)",
                     $time, Mispredict_o, x_mis, RedirectPC_o, x_red, BTB_we_o, x_btbwe,
                     BTBwriteaddress_o, x_baddr, BTBwritedata_o, x_data, UpdatePC_o, x_upc,
                     PHTwe_o, x_phtwe, PHTincrement_o, x_inc, PHTwriteaddress_o, x_paddr,
                     GHRreset_o, x_ghr);
        end
`ifdef BP_RESOLVE_STATS_EN
        checks++;
        if (BranchCount_o !== m_bc || MispredictCount_o !== m_mc) begin
            errors++;
            $display("FAIL stats got %0d/%0d exp %0d/%0d", BranchCount_o, MispredictCount_o, m_bc, m_mc);
        end
`endif
    endtask

    // Clock edge: advance the reference pipe.
    task automatic adv();
        rec_t nE;
        @(posedge clk);
        if (reset_i) begin
            mD = '0;
            mE = '0;
`ifdef BP_RESOLVE_STATS_EN
            m_bc = 0;
            m_mc = 0;
`endif
        end else begin
`ifdef BP_RESOLVE_STATS_EN
            if (x_ctl && m_bc != 32'hFFFF_FFFF) m_bc++;
            if (x_mis && m_mc != 32'hFFFF_FFFF) m_mc++;
`endif
            nE = mD;
            if (FlushE_i || x_mis) nE.v = 1'b0;
            if (FlushD_i) mD.v = 1'b0;
            else if (!StallD_i)
                mD = '{1'b1, PCF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i};
            mE = nE;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Push one record into F, then a filler, so it sits in E afterwards.
    task automatic load(input logic [31:0] pc, input logic pt, input logic [31:0] tgt, input logic [4:0] pht);
        StallD_i = 0; FlushD_i = 0; FlushE_i = 0;
        opE_i = OP_ADD; ActualTakenE_i = 0; ActualTargetE_i = 0;
        PCF_i = pc; BranchTakenF_i = pt; BTBtargetF_i = tgt; PHTreadaddressF_i = pht;
        settle(); adv();
        PCF_i = 32'h900; BranchTakenF_i = 0; BTBtargetF_i = 0; PHTreadaddressF_i = 0;
        settle(); adv();
    endtask

    task automatic resolve(input logic [6:0] op, input logic at, input logic [31:0] atgt);
        opE_i = op; ActualTakenE_i = at; ActualTargetE_i = atgt;
        settle();
    endtask

    task automatic test_reset();
        reset_i = 1;
        settle(); adv();
        settle();
        chk("reset_mis", 32'(Mispredict_o), 0);
        chk("reset_updpc", UpdatePC_o, 0);
        adv();
        reset_i = 0;
    endtask

    task automatic test_branches();
        load(32'h40, 0, 32'h0, 5'd3);
        resolve(OP_BR, 0, 32'h44);
        chk("nt_phtwe", 32'(PHTwe_o), 1);
        chk("nt_inc", 32'(PHTincrement_o), 0);
        chk("nt_mis", 32'(Mispredict_o), 0);
        chk("nt_btbwe", 32'(BTB_we_o), 0);
        chk("nt_paddr", 32'(PHTwriteaddress_o), 3);
        adv();
        load(32'h44, 0, 32'h999, 5'd4);
        resolve(OP_BR, 1, 32'h10);
        chk("tk_mis", 32'(Mispredict_o), 1);
        chk("tk_red", RedirectPC_o, 32'h10);
        chk("tk_btbwe", 32'(BTB_we_o), 1);
        chk("tk_baddr", 32'(BTBwriteaddress_o), 17);
        chk("tk_data", BTBwritedata_o, 32'h10);
        chk("tk_ghr", 32'(GHRreset_o), 1);
        adv();
        resolve(OP_BR, 1, 32'h10);
        chk("squash_mis", 32'(Mispredict_o), 0);
        chk("squash_phtwe", 32'(PHTwe_o), 0);
        chk("squash_btbwe", 32'(BTB_we_o), 0);
        adv();
    endtask

    task automatic test_jumps_alias();
        load(32'h80, 1, 32'h200, 5'd1);
        resolve(OP_JAL, 0, 32'h200);
        chk("jal_ok_mis", 32'(Mispredict_o), 0);
        chk("jal_ok_phtwe", 32'(PHTwe_o), 0);
        chk("jal_ok_btbwe", 32'(BTB_we_o), 0);
        adv();
        load(32'h80, 1, 32'h100, 5'd1);
        resolve(OP_JALR, 0, 32'h200);
        chk("jal_stale_mis", 32'(Mispredict_o), 1);
        chk("jal_stale_red", RedirectPC_o, 32'h200);
        chk("jal_stale_btbwe", 32'(BTB_we_o), 1);
        chk("jal_stale_ghr", 32'(GHRreset_o), 0);
        adv();
        load(32'h0C, 1, 32'h500, 5'd2);
        resolve(OP_ADD, 1, 32'h500);
        chk("alias_mis", 32'(Mispredict_o), 1);
        chk("alias_red", RedirectPC_o, 32'h10);
        chk("alias_btbwe", 32'(BTB_we_o), 0);
        chk("alias_phtwe", 32'(PHTwe_o), 0);
        adv();
    endtask

    task automatic test_stall_flush();
        opE_i = OP_BR; ActualTakenE_i = 1; ActualTargetE_i = 32'h300;
        PCF_i = 32'h60; BranchTakenF_i = 1; BTBtargetF_i = 32'h300; PHTreadaddressF_i = 7;
        settle(); adv();
        StallD_i = 1; PCF_i = 32'h64;
        repeat (2) begin settle(); adv(); end
        chk("stall_held_pc", UpdatePC_o, 32'h60);
        FlushD_i = 1; FlushE_i = 1;
        settle(); adv();
        StallD_i = 0; FlushD_i = 0; FlushE_i = 0;
        settle();
        chk("flush_phtwe", 32'(PHTwe_o), 0);
        chk("flush_upc", UpdatePC_o, 0);
        adv();
        settle();
        chk("flush_d_phtwe", 32'(PHTwe_o), 0);
        adv();
        load(32'h70, 0, 32'h0, 5'd9);
        opE_i = OP_BR; ActualTakenE_i = 1; ActualTargetE_i = 32'h20;
        reset_i = 1;
        settle();
        chk("rst_cycle_mis", 32'(Mispredict_o), 0);
        chk("rst_cycle_phtwe", 32'(PHTwe_o), 0);
        adv();
        reset_i = 0;
        settle();
        chk("rst_after_phtwe", 32'(PHTwe_o), 0);
        chk("rst_after_btbwe", 32'(BTB_we_o), 0);
        adv();
    endtask

    task automatic test_random();
        logic [31:0] tgts [4];
        tgts[0] = 32'h100; tgts[1] = 32'h200; tgts[2] = 32'h0; tgts[3] = 32'hFFFF_FFFC;
        for (int i = 0; i < 600; i++) begin
            reset_i  = ($urandom_range(99) < 3);
            StallD_i = ($urandom_range(99) < 20);
            FlushD_i = ($urandom_range(99) < 10);
            FlushE_i = ($urandom_range(99) < 10);
            PCF_i    = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            BranchTakenF_i    = $urandom_range(1);
            BTBtargetF_i      = tgts[$urandom_range(3)];
            PHTreadaddressF_i = 5'($urandom());
            case ($urandom_range(4))
                0, 1: opE_i = OP_BR;
                2:    opE_i = OP_JAL;
                3:    opE_i = OP_JALR;
                default: opE_i = OP_ADD;
            endcase
            ActualTakenE_i  = $urandom_range(1);
            ActualTargetE_i = $urandom_range(1) ? mE.tgt : tgts[$urandom_range(3)];
            settle(); adv();
        end
        reset_i = 0; StallD_i = 0; FlushD_i = 0; FlushE_i = 0;
    endtask

`ifdef BP_RESOLVE_STATS_EN
    task automatic test_stats();
        reset_i = 1; settle(); adv(); reset_i = 0;
        load(32'h100, 0, 32'h0, 5'd0);
        resolve(OP_BR, 0, 32'h0); adv();
        load(32'h104, 1, 32'h40, 5'd0);
        resolve(OP_BR, 1, 32'h40); adv();
        load(32'h108, 0, 32'h0, 5'd0);
        resolve(OP_BR, 1, 32'h80); adv();
        opE_i = OP_ADD;
        settle();
        chk("stats_br", BranchCount_o, 3);
        chk("stats_mis", MispredictCount_o, 1);
        adv();
    endtask
`endif

    initial begin
`ifdef BP_RESOLVE_STATS_EN
        m_bc = 0;
        m_mc = 0;
`endif
        test_reset();
        test_branches();
        test_jumps_alias();
        test_stall_flush();
        test_random();
`ifdef BP_RESOLVE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
